uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Upstream stage of the 64-bit UART transmit path.
- Accepts 64-bit words from a valid/ready source and writes them into the transmit FIFO of the 64-bit UART transmitter.
- Schedules one-cycle enable pulses so the transmitter drains one word at a time, with a programmable inter-word idle gap.
- Reports words sent and a sticky timeout error for a transmitter that never acknowledges.

Parameters:
- GAP_CYC, 16, idle clocks inserted after each word completes before the next launch; 0 means no gap state.
- BUSY_TO, 8, max clocks from enable pulse to tx_busy rising before a timeout is declared; legal range 4..255.
- CNT_W, 16, width of the words_sent counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s_data  in  64  upstream word
- s_valid  in  1  upstream word valid
- s_ready  out  1  feeder can accept a word
- run  in  1  launch enable; 0 stops new launches, FIFO writes still accepted
- clr_err  in  1  one-cycle pulse, clears err_timeout
- fifo_din  out  64  to transmitter FIFO data
- fifo_wr_en  out  1  to transmitter FIFO write
- fifo_full  in  1  from transmitter FIFO
- fifo_empty  in  1  from transmitter FIFO
- tx_enable  out  1  one-clk launch pulse to transmitter
- tx_busy  in  1  transmitter busy; high while the 8 bytes of a word are being sent
- words_sent  out  CNT_W  completed words, wraps modulo 2^CNT_W
- err_timeout  out  1  sticky; tx_busy failed to rise within BUSY_TO clocks
- state_idle  out  1  high when the FSM is in IDLE

Behaviour:
- Write side is combinational pass-through:
  - s_ready = ~fifo_full.
  - fifo_wr_en = s_valid & ~fifo_full.
  - fifo_din = s_data.
  - A word transfers on each clk where s_valid & s_ready. No internal buffering.
- FSM states IDLE, FIRE, WAIT_BUSY, WAIT_DONE, GAP. Reset state is IDLE.
  - IDLE: when run & ~fifo_empty & ~tx_busy, go to FIRE.
  - FIRE: lasts 1 clk. tx_enable is registered and high exactly in this cycle. Next state is WAIT_BUSY; the timeout counter clears to 0.
  - WAIT_BUSY: timeout counter increments each clk.
    - If tx_busy=1, go to WAIT_DONE. tx_busy takes priority when it coincides with the timeout count.
    - Else if the counter reaches BUSY_TO-1, set err_timeout and go to GAP (or IDLE if GAP_CYC=0).
  - WAIT_DONE: on the tx_busy 1->0 transition (tx_busy=0 in this state), words_sent increments and the FSM goes to GAP, or IDLE if GAP_CYC=0.
  - GAP: gap counter runs 0..GAP_CYC-1, then the FSM goes to IDLE. run=0 does not abort an in-flight word or gap.
- Throughput: the minimum spacing between consecutive tx_enable pulses is transmitter word time + GAP_CYC + 2 clks (WAIT_DONE exit + IDLE decision).
- fifo_empty is sampled only in IDLE. The FSM never pulses tx_enable while fifo_empty=1, so every pulse reads exactly one word.
- err_timeout:
  - Set in the WAIT_BUSY timeout cycle.
  - Cleared by clr_err.
  - If set and clear occur in the same clk, set wins.
- words_sent wraps from 2^CNT_W-1 to 0 with no flag.
- Simultaneous write and launch are independent. A write to an empty FIFO may be launched as early as the clk after fifo_empty deasserts.
- Reset (async, any time, including mid-word):
  - FSM goes to IDLE; all counters go to 0.
  - tx_enable=0, words_sent=0, err_timeout=0, state_idle=1.
  - s_ready and fifo_wr_en follow fifo_full immediately; the transmitter and FIFO are reset by the same rst_n.

Test Plan:
- Reset, then write 3 words (0x0706050403020100, 0x1111..., 0x2222...) with run=1 and a transmitter model whose busy rises 2 clks after enable and lasts 80 clks -> exactly 3 tx_enable pulses, each 1 clk wide, spaced ≥ 80+GAP_CYC+2 clks; words_sent=3; err_timeout=0.
- Hold fifo_full=1 with s_valid=1 for 10 clks -> s_ready=0 and fifo_wr_en=0 throughout; both rise in the same clk fifo_full falls.
- Model never raises busy after an enable, BUSY_TO=8 -> err_timeout sets exactly 8 clks after the tx_enable cycle and the FSM returns through GAP; clr_err pulse clears it; clr_err in the same clk as a second timeout leaves err_timeout=1.
- run=0 with 2 words queued -> no tx_enable pulse; run raised to 1 -> first pulse 2 clks later (IDLE decision + FIRE); run dropped mid-word -> current word completes and no further pulse follows.
- CNT_W=4, send 17 words -> words_sent reads 1 after the 17th completion.
- Assert rst_n low during WAIT_DONE -> tx_enable=0, words_sent=0, state_idle=1 asynchronously; after release with FIFO non-empty and run=1 -> launch resumes normally.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Feeds 64-bit words into the UART transmitter FIFO and paces one-cycle launch
// pulses to the transmitter, with an idle gap, a completion count and a busy timeout.
module uart_tx_feeder #(
  parameter int unsigned GAP_CYC = 16,
  parameter int unsigned BUSY_TO = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             run,
  input  logic             clr_err,
  output logic [63:0]      fifo_din,
  output logic             fifo_wr_en,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             tx_enable,
  input  logic             tx_busy,
  output logic [CNT_W-1:0] words_sent,
  output logic             err_timeout,
  output logic             state_idle
);

  localparam int unsigned      GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  // The counter is compared before its increment, so BUSY_TO-2 here means the
  // incremented value has reached BUSY_TO-1.
  localparam logic [7:0]       TO_LAST  = 8'(BUSY_TO - 2);

  typedef enum logic [2:0] {
    IDLE,
    FIRE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_e;

  localparam state_e AFTER_WORD = (GAP_CYC == 0) ? IDLE : GAP;

  state_e           state_q, state_d;
  logic [7:0]       to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             err_q, err_d;
  logic             tx_en_q, tx_en_d;

  // Write side is a pure pass-through; the FIFO itself provides buffering.
  assign s_ready    = ~fifo_full;
  assign fifo_wr_en = s_valid & ~fifo_full;
  assign fifo_din   = s_data;

  assign tx_enable   = tx_en_q;
  assign words_sent  = words_q;
  assign err_timeout = err_q;
  assign state_idle  = (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    words_d   = words_q;
    err_d     = err_q & ~clr_err;
    tx_en_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (run && !fifo_empty && !tx_busy) begin
          state_d = FIRE;
          tx_en_d = 1'b1;
        end
      end
      FIRE: begin
        state_d  = WAIT_BUSY;
        to_cnt_d = 8'd0;
      end
      WAIT_BUSY: begin
        to_cnt_d = to_cnt_q + 8'd1;
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          // Setting overrides a clear arriving in the same cycle.
          err_d     = 1'b1;
          state_d   = AFTER_WORD;
          gap_cnt_d = '0;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          words_d   = words_q + 1'b1;
          state_d   = AFTER_WORD;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      to_cnt_q  <= 8'd0;
      gap_cnt_q <= '0;
      words_q   <= '0;
      err_q     <= 1'b0;
      tx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      words_q   <= words_d;
      err_q     <= err_d;
      tx_en_q   <= tx_en_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: FIFO and transmitter models plus a timeline-based
// reference that predicts every launch, completion, timeout and idle period.
module tb_uart_tx_feeder;

  localparam int GAP   = 16;
  localparam int BTO   = 8;
  localparam int CW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          run = 1'b0;
  logic          clr_err = 1'b0;
  logic [63:0]   fifo_din;
  logic          fifo_wr_en;
  logic          fifo_full = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          tx_enable;
  logic          tx_busy = 1'b0;
  logic [CW-1:0] words_sent;
  logic          err_timeout;
  logic          state_idle;

  always #5 clk = ~clk;

  uart_tx_feeder #(.GAP_CYC(GAP), .BUSY_TO(BTO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .run(run), .clr_err(clr_err), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .tx_enable(tx_enable),
    .tx_busy(tx_busy), .words_sent(words_sent), .err_timeout(err_timeout),
    .state_idle(state_idle)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference timeline: cycle numbers at which each predicted event happens.
  int cyc = 0, cnt = 0, fire_at = -1, bs = -1, be = -1, ws_at = -1, err_at = -1;
  int idle_from = 0, done_cnt = 0;
  bit prev_wr, prev_pop, exp_fire, idle_exp, exp_err, exp_err_next;
  logic [CW-1:0] exp_ws;

  // Stimulus knobs.
  logic sv = 1'b0, run_i = 1'b0, clr_i = 1'b0, force_full = 1'b0;
  logic [63:0] sd = '0;
  bit never_busy = 1'b0, rand_tx = 1'b0;
  int rise_cfg = 2, len_cfg = 80;

  int n_pulse = 0, last_pulse = -1, min_space = 1000000;

  typedef struct {
    logic        v;
    logic        f;
    logic [63:0] d;
    logic        er;
    logic        ew;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cnt = 0; prev_wr = 0; prev_pop = 0;
    fire_at = -1; bs = -1; be = -1; ws_at = -1; err_at = -1;
    idle_from = 0; exp_ws = '0; exp_err = 0; exp_err_next = 0;
    sv = 0; force_full = 0; clr_i = 0;
  endtask

  // Word launched at cycle f: the transmitter raises busy r cycles later for l
  // cycles, or never answers, in which case the timeout fires BTO cycles later.
  task automatic schedule(input int f);
    int r, l;
    fire_at = f;
    if (never_busy) begin
      bs = -1; be = -1;
      err_at = f + BTO;
      idle_from = f + BTO + GAP;
    end else begin
      r = rand_tx ? int'($urandom_range(BTO - 1, 1)) : rise_cfg;
      l = rand_tx ? int'($urandom_range(12, 1)) : len_cfg;
      bs = f + r;
      be = bs + l;
      ws_at = be + 1;
      idle_from = be + GAP + 1;
    end
  endtask

  task automatic tick();
    bit busy_now, full_now;
    @(negedge clk);
    cyc++;
    cnt = cnt + int'(prev_wr) - int'(prev_pop);
    exp_fire = (cyc == fire_at);
    if (cyc == ws_at) begin
      exp_ws = exp_ws + 1'b1;
      done_cnt++;
    end
    exp_err = exp_err_next;
    idle_exp = (cyc >= idle_from);
    chk("tx_enable", 64'(tx_enable), 64'(exp_fire));
    chk("state_idle", 64'(state_idle), 64'(idle_exp));
    chk("words_sent", 64'(words_sent), 64'(exp_ws));
    chk("err_timeout", 64'(err_timeout), 64'(exp_err));
    if (tx_enable) begin
      n_pulse++;
      if (last_pulse >= 0 && cyc - last_pulse < min_space) min_space = cyc - last_pulse;
      last_pulse = cyc;
      $display("launch %0d at cycle %0d, words_sent=%0d", n_pulse, cyc, words_sent);
    end
    busy_now = (cyc >= bs) && (cyc < be);
    full_now = force_full || (cnt == DEPTH);
    s_valid = sv; s_data = sd; run = run_i; clr_err = clr_i;
    tx_busy = busy_now; fifo_empty = (cnt == 0); fifo_full = full_now;
    #1;
    chk("s_ready", 64'(s_ready), 64'(!full_now));
    chk("fifo_wr_en", 64'(fifo_wr_en), 64'(sv && !full_now));
    chk("fifo_din", fifo_din, sd);
    prev_wr = sv && !full_now;
    prev_pop = exp_fire;
    if (idle_exp && run_i && cnt != 0 && !busy_now) schedule(cyc + 1);
    exp_err_next = (cyc + 1 == err_at) ? 1'b1 : (clr_i ? 1'b0 : exp_err);
  endtask

  // Asynchronous reset asserted between clock edges, released on a falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    s_valid = 1'b0; fifo_empty = 1'b1; fifo_full = 1'b0; tx_busy = 1'b0; clr_err = 1'b0;
    #1;
    chk("rst_tx_enable", 64'(tx_enable), 64'd0);
    chk("rst_words_sent", 64'(words_sent), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_state_idle", 64'(state_idle), 64'd1);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, p_cyc, e_cyc, old_at, d0;
    logic [63:0] w3 [3];

    for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, 1'b1, 64'hA5A5_0000_0000_0000 + 64'(i), 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 64'hA5A5_0000_0000_00AA, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    w3[0] = 64'h0706050403020100;
    w3[1] = 64'h1111111111111111;
    w3[2] = 64'h2222222222222222;

    do_reset();

    // Three words through a transmitter with 2-cycle rise and 80-cycle busy.
    never_busy = 0; rand_tx = 0; rise_cfg = 2; len_cfg = 80; run_i = 1;
    p0 = n_pulse; last_pulse = -1; min_space = 1000000;
    for (int i = 0; i < 3; i++) begin
      sv = 1; sd = w3[i];
      tick();
    end
    sv = 0;
    for (int n = 0; n < 600 && exp_ws != 3; n++) tick();
    repeat (3) tick();
    chk("t1_pulses", 64'(n_pulse - p0), 64'd3);
    chk("t1_words", 64'(words_sent), 64'd3);
    chk("t1_err", 64'(err_timeout), 64'd0);
    chk("t1_min_spacing", 64'(min_space >= 80 + GAP + 2), 64'd1);
    repeat (GAP) tick();

    // Full FIFO blocks the write side; run held low so nothing launches.
    run_i = 0;
    for (int i = 0; i < 14; i++) begin
      sv = tbl[i].v; force_full = tbl[i].f; sd = tbl[i].d;
      tick();
      chk("tbl_s_ready", 64'(s_ready), 64'(tbl[i].er));
      chk("tbl_wr_en", 64'(fifo_wr_en), 64'(tbl[i].ew));
      chk("tbl_din", fifo_din, tbl[i].d);
    end
    sv = 0; force_full = 0;

    // Two queued words with run low, then run raised, then dropped mid-word.
    sv = 1; sd = 64'h3333333333333333;
    tick();
    sv = 0;
    p0 = n_pulse;
    repeat (20) tick();
    chk("run0_no_pulse", 64'(n_pulse - p0), 64'd0);
    rise_cfg = 2; len_cfg = 30; run_i = 1;
    tick();
    tick();
    chk("run_rise_launch", 64'(tx_enable), 64'd1);
    repeat (5) tick();
    run_i = 0;
    repeat (30 + GAP + 10) tick();
    chk("run_drop_single", 64'(n_pulse - p0), 64'd1);
    chk("run_drop_words", 64'(words_sent), 64'd4);

    // Transmitter that never answers: timeout latency, clear, then set-wins.
    never_busy = 1; run_i = 1;
    p_cyc = -1; e_cyc = -1;
    for (int n = 0; n < 100 && e_cyc < 0; n++) begin
      tick();
      if (tx_enable && p_cyc < 0) p_cyc = cyc;
      if (err_timeout && e_cyc < 0) e_cyc = cyc;
    end
    chk("timeout_latency", 64'(e_cyc - p_cyc), 64'(BTO));
    run_i = 0;
    repeat (GAP + 2) tick();
    clr_i = 1;
    tick();
    clr_i = 0;
    tick();
    chk("clr_err", 64'(err_timeout), 64'd0);
    old_at = err_at;
    sv = 1; sd = 64'h4444444444444444; run_i = 1;
    tick();
    sv = 0;
    for (int n = 0; n < 60; n++) begin
      clr_i = (err_at != old_at) && (cyc + 1 == err_at - 1);
      tick();
      if (err_at != old_at && cyc >= err_at) break;
    end
    clr_i = 0;
    chk("set_wins_over_clr", 64'(err_timeout), 64'd1);
    run_i = 0; never_busy = 0;
    repeat (GAP + 4) tick();
    clr_i = 1;
    tick();
    clr_i = 0;
    tick();

    // Reset in the middle of a word, then a fresh launch.
    sv = 1; sd = 64'h5555555555555555; run_i = 1; rise_cfg = 2; len_cfg = 40;
    tick();
    sv = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (bs >= 0 && cyc >= bs && cyc < be) break;
    end
    repeat (5) tick();
    chk("pre_reset_busy_word", 64'(state_idle), 64'd0);
    do_reset();
    sv = 1; sd = 64'h6666666666666666;
    tick();
    sv = 0;
    p0 = n_pulse;
    repeat (20) tick();
    chk("resume_pulse", 64'(n_pulse - p0), 64'd1);

    // Randomized traffic until 17 words complete; the 4-bit counter wraps to 1.
    do_reset();
    rand_tx = 1; never_busy = 0;
    d0 = done_cnt;
    for (int n = 0; n < 3000 && done_cnt - d0 < 17; n++) begin
      sv = $urandom_range(1, 0);
      sd = {$urandom, $urandom};
      run_i = ($urandom_range(9, 0) != 0);
      force_full = ($urandom_range(7, 0) == 0);
      clr_i = ($urandom_range(7, 0) == 0);
      tick();
    end
    chk("wrap_after_17", 64'(words_sent), 64'd1);
    chk("random_no_timeout", 64'(err_timeout), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
